mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port, word-addressed synchronous memory between the fetch stage (read-only) and the data-memory stage (read/write).
//  Grants one requester per cycle: data has priority; a starvation counter forces a fetch grant.
//  Tracks in-flight reads and routes each response to its owner after a fixed latency.
//  if_flush squashes in-flight fetch responses on branch redirect.
// PARAMETERS
//  MEM_LAT     1  memory read latency in cycles (>=1); mem_rdata valid MEM_LAT cycles after mem_en
//  STARVE_MAX  4  consecutive data grants with fetch waiting before fetch is forced through (>=1)
// PORTS
//  clk        in   1   clock; all state updates on posedge
//  reset      in   1   synchronous, active-high
//  if_req     in   1   fetch read request; held until if_gnt
//  if_addr    in   30  fetch word address
//  if_flush   in   1   squash all in-flight fetch reads; block fetch grant this cycle
//  if_gnt     out  1   fetch request accepted this cycle (combinational)
//  if_rvalid  out  1   fetch read data valid
//  if_rdata   out  32  fetch read data (= mem_rdata; meaningful only with if_rvalid)
//  dm_req     in   1   data request; held until dm_gnt
//  dm_we      in   1   1 = write, 0 = read
//  dm_be      in   4   write byte enables
//  dm_addr    in   30  data word address
//  dm_wdata   in   32  write data
//  dm_gnt     out  1   data request accepted this cycle (combinational)
//  dm_rvalid  out  1   data read data valid (reads only; writes never respond)
//  dm_rdata   out  32  data read data (= mem_rdata; meaningful only with dm_rvalid)
//  mem_en     out  1   memory access this cycle
//  mem_we     out  1   memory write strobe
//  mem_be     out  4   byte enables (4'hF for fetch)
//  mem_addr   out  30  memory word address
//  mem_wdata  out  32  memory write data (0 for fetch)
//  mem_rdata  in   32  memory read data
// BEHAVIOUR
//  Reset: state=NORMAL, starve_cnt=0, all tags invalid; while reset=1 all gnt/rvalid/mem_en/mem_we = 0.
//  Grant (combinational from reqs + state): single requester -> granted.
//    Both, NORMAL -> dm. Both, STARVED -> if.
//    if_flush=1 -> if_gnt=0 that cycle; dm may still be granted.
//  Memory drive is a mux of the granted requester in the grant cycle; mem_en = if_gnt|dm_gnt.
//  FSM:
//    NORMAL->STARVED when dm_gnt & if_req & ~if_flush & starve_cnt==STARVE_MAX-1.
//    STARVED->NORMAL when if_gnt or ~if_req.
//  starve_cnt: +1 on dm_gnt with if_req pending; cleared on if_gnt or ~if_req; never exceeds STARVE_MAX-1.
//  Tag pipe: MEM_LAT stages of {valid, owner}; loaded on every read grant (dm writes load invalid).
//    Stage MEM_LAT-1 valid -> owner's rvalid=1 for exactly one cycle; rdata = mem_rdata.
//    Fully pipelined: back-to-back reads return back-to-back, in grant order.
//  if_flush: clears valid of every IF-owned tag, including the one emerging this cycle (if_rvalid=0 that cycle); DM tags untouched.
//  Reset mid-operation: all in-flight tags dropped; no rvalid after reset deasserts for pre-reset grants.
// STRUCTURE
//  Header mem_defs.vh: OWNER_IF=1'b0, OWNER_DM=1'b1, ADDR_W=30, DATA_W=32, BE_ALL=4'hF, ST_NORMAL/ST_STARVED encodings.
//  Sub-module mem_tag_pipe (MEM_LAT): shift register of {valid,owner}, with push, flush_if, synchronous clear.
//  Top: grant logic, FSM + starve_cnt, memory mux, response demux.
// TESTING
//  1. Reset for 2 cycles with both reqs high -> no gnt, mem_en=0; first cycle after reset dm_gnt=1.
//  2. if_req only, addr 0,1,2 back-to-back, MEM_LAT=1 -> if_gnt each cycle; if_rvalid next cycle, with mem_rdata for each addr in order.
//  3. Both reqs held, STARVE_MAX=4 -> grant sequence dm,dm,dm,dm,if,dm,dm,dm,dm,if.
//  4. dm write (we=1, be=4'b0011, addr 0x10, wdata 0xDEADBEEF) -> mem_we=1, mem_be=4'b0011 that cycle; no dm_rvalid ever.
//  5. MEM_LAT=2: fetch reads granted at t0,t1; if_flush at t2 -> no if_rvalid at t2 or t3; dm read granted at t1 instead -> dm_rvalid at t3.
//  6. Reset asserted one cycle after read grant -> no rvalid on either port; tag pipe empty after reset.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and constants for the memory port arbiter
// Purpose: owner encodings, bus widths, FSM state encoding, tag type and a
//   helper deciding whether a tag survives a fetch flush.
// Ports: none (package).
package mem_port_arbiter_pkg;

  localparam logic       OWNER_IF = 1'b0;
  localparam logic       OWNER_DM = 1'b1;
  localparam int         ADDR_W   = 30;
  localparam int         DATA_W   = 32;
  localparam logic [3:0] BE_ALL   = 4'hF;

  typedef enum logic {
    ST_NORMAL  = 1'b0,
    ST_STARVED = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic valid;
    logic owner;
  } tag_t;

  // A fetch flush kills every fetch-owned tag; data tags are never touched.
  function automatic logic tag_survives(tag_t tag, logic flush_if);
    return tag.valid & ~(flush_if & (tag.owner == OWNER_IF));
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, data and memory buses of the memory port arbiter
// Purpose: bundles the fetch request/response, data request/response and the
//   single-port memory bus.
// Ports (modports):
//   slave  - arbiter view: requests and mem_rdata in; grants, responses, memory drive out
//   master - environment view: the reverse
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [3:0]        dm_be;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, if_flush,
    output if_gnt, if_rvalid, if_rdata,
    input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr, if_flush,
    input  if_gnt, if_rvalid, if_rdata,
    output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mem_port_arbiter_tag_pipe.sv
// rtl/mem_port_arbiter_tag_pipe.sv - in-flight read tag shift register
// Purpose: MEM_LAT-deep shift register of {valid, owner}; the last stage marks
//   which requester owns mem_rdata this cycle.
// Ports:
//   clk, reset  - clock, synchronous active-high clear
//   i_push      - a read was granted this cycle
//   i_owner     - owner of the granted read
//   i_flush_if  - kill every fetch-owned tag, including the emerging one
//   o_valid     - last stage holds a live tag
//   o_owner     - owner of the last stage
module mem_port_arbiter_tag_pipe
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_push,
  input  logic i_owner,
  input  logic i_flush_if,
  output logic o_valid,
  output logic o_owner
);

  tag_t r_pipe [MEM_LAT];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MEM_LAT; i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      // A flush never coincides with a fetch push (fetch grant is blocked),
      // so stage 0 can be loaded unconditionally.
      r_pipe[0].valid <= i_push;
      r_pipe[0].owner <= i_owner;
      for (int i = 1; i < MEM_LAT; i++) begin
        r_pipe[i].valid <= tag_survives(r_pipe[i-1], i_flush_if);
        r_pipe[i].owner <= r_pipe[i-1].owner;
      end
    end
  end

  assign o_valid = tag_survives(r_pipe[MEM_LAT-1], i_flush_if);
  assign o_owner = r_pipe[MEM_LAT-1].owner;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter for fetch and data stages
// Purpose: grants one requester per cycle (data first; fetch forced through
//   after STARVE_MAX consecutive data grants while it waits), drives the memory
//   from the winner and routes read data to its owner MEM_LAT cycles later.
// Ports:
//   clk    - clock, all state on posedge
//   reset  - synchronous active-high reset
//   bus    - slave side of mem_port_arbiter_if (fetch, data and memory buses)
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  localparam int              CNT_W   = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX - 1);

  arb_state_e       r_state;
  arb_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_starve_cnt;
  logic [CNT_W-1:0] w_starve_cnt_nxt;
  logic             w_if_cand;
  logic             w_if_gnt;
  logic             w_dm_gnt;
  logic             w_push;
  logic             w_push_owner;
  logic             w_tag_valid;
  logic             w_tag_owner;

  // Fetch is only a candidate when not being flushed this cycle.
  assign w_if_cand = bus.if_req & ~bus.if_flush;

  always_comb begin
    w_if_gnt = 1'b0;
    w_dm_gnt = 1'b0;
    if (!reset) begin
      if (bus.dm_req && w_if_cand) begin
        if (r_state == ST_STARVED) begin
          w_if_gnt = 1'b1;
        end else begin
          w_dm_gnt = 1'b1;
        end
      end else begin
        w_if_gnt = w_if_cand;
        w_dm_gnt = bus.dm_req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_NORMAL;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_starve_cnt_nxt = r_starve_cnt;

    unique case (r_state)
      ST_NORMAL: begin
        if (w_dm_gnt && w_if_cand && (r_starve_cnt == CNT_MAX)) begin
          w_state_nxt = ST_STARVED;
        end
      end
      ST_STARVED: begin
        if (w_if_gnt || !bus.if_req) begin
          w_state_nxt = ST_NORMAL;
        end
      end
      default: w_state_nxt = ST_NORMAL;
    endcase

    // Saturates at STARVE_MAX-1; the FSM does the forcing from there.
    if (w_if_gnt || !bus.if_req) begin
      w_starve_cnt_nxt = '0;
    end else if (w_dm_gnt && (r_starve_cnt != CNT_MAX)) begin
      w_starve_cnt_nxt = r_starve_cnt + CNT_W'(1);
    end
  end

  assign bus.if_gnt    = w_if_gnt;
  assign bus.dm_gnt    = w_dm_gnt;

  assign bus.mem_en    = w_if_gnt | w_dm_gnt;
  assign bus.mem_we    = w_dm_gnt & bus.dm_we;
  assign bus.mem_be    = w_dm_gnt ? bus.dm_be    : BE_ALL;
  assign bus.mem_addr  = w_dm_gnt ? bus.dm_addr  : bus.if_addr;
  assign bus.mem_wdata = w_dm_gnt ? bus.dm_wdata : '0;

  // Writes load an invalid tag so they never produce a response.
  assign w_push       = w_if_gnt | (w_dm_gnt & ~bus.dm_we);
  assign w_push_owner = w_dm_gnt ? OWNER_DM : OWNER_IF;

  mem_port_arbiter_tag_pipe #(
    .MEM_LAT (MEM_LAT)
  ) u_tag_pipe (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_push),
    .i_owner    (w_push_owner),
    .i_flush_if (bus.if_flush),
    .o_valid    (w_tag_valid),
    .o_owner    (w_tag_owner)
  );

  // Tags are cleared only at the edge, so gate the emerging one during reset.
  assign bus.if_rvalid = ~reset & w_tag_valid & (w_tag_owner == OWNER_IF);
  assign bus.dm_rvalid = ~reset & w_tag_valid & (w_tag_owner == OWNER_DM);
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.dm_rdata  = bus.mem_rdata;

endmodule
